serial_deser: RTL

Serial-to-parallel receiver for the 8-bit rotating shift-register datapath. It collects a bit stream, one bit per qualified clock, into a `WIDTH`-bit word, either MSB-first or LSB-first. It presents each completed word on a held output register with a valid/ack handshake. It is the receiving end of the parallel-load shift register link and recovers the word that register shifts out.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/sipo_shifter.sv | 49 ++++
 rtl/serial_deser.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial receiver: word width, direction encoding and bit-count derivation.
// Build option: SERIAL_DESER_PARITY_EN appends one even-parity bit to every word.
package serial_pkg;

   localparam int DATA_W = 8;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

`ifdef SERIAL_DESER_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Serial bits per word, including the trailing parity bit when enabled.
   function automatic int nbits(input int width);
      return width + PARITY_BITS;
   endfunction

   function automatic int cnt_width(input int width);
      return $clog2(nbits(width) + 1);
   endfunction

endpackage

// File: rtl/sipo_shifter.sv
// WIDTH-bit serial-in shift register with direction select, shift enable and synchronous clear.
// word_o optionally bypasses the incoming bit so a completing word is visible on its final edge.
module sipo_shifter
   import serial_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             shift_en_i,
   input  logic             dir_i,
   input  logic             sin_i,
   input  logic             sclr_i,
   input  logic             bypass_i,
   output logic [WIDTH-1:0] word_o
);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      if (dir_i == DIR_RIGHT) begin
         shifted = {sin_i, shift_q[WIDTH-1:1]};
      end else begin
         shifted = {shift_q[WIDTH-2:0], sin_i};
      end
   end

   always_comb begin
      shift_d = shift_q;
      if (sclr_i) begin
         shift_d = '0;
      end else if (shift_en_i) begin
         shift_d = shifted;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign word_o = bypass_i ? shifted : shift_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: bit counter, direction latch, valid/ack holding register, overrun and parity.
// Build option: SERIAL_DESER_PARITY_EN enables the trailing even-parity bit and parity_err.
module serial_deser
   import serial_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             rright,
   input  logic             sclr,
   input  logic             dout_ack,
   output logic [WIDTH-1:0] dataout,
   output logic             dout_valid,
   output logic             overrun,
   output logic             parity_err
);

   localparam int NBITS = nbits(WIDTH);
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(WIDTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dv_q, dv_d;
   logic             ovr_q, ovr_d;
   logic             perr_q, perr_d;

   logic             bit_take;
   logic             dir_eff;
   logic             shift_en;
   logic             word_done;
   logic [WIDTH-1:0] word;
   logic             word_par;

   assign bit_take  = sin_valid & ~sclr;
   // The first bit of a word follows the live rright; later bits use the latched value.
   assign dir_eff   = (cnt_q == '0) ? rright : dir_q;
   assign shift_en  = bit_take & (cnt_q < CNT_DATA);
   assign word_done = bit_take & (cnt_q == CNT_LAST);

   sipo_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk        (clk),
      .resetn     (resetn),
      .shift_en_i (shift_en),
      .dir_i      (dir_eff),
      .sin_i      (sin),
      .sclr_i     (sclr),
      .bypass_i   (PARITY_BITS == 0),
      .word_o     (word)
   );

`ifdef SERIAL_DESER_PARITY_EN
   // Data is already complete when the parity bit arrives; even parity over data plus parity bit.
   assign word_par = (^word) ^ sin;
`else
   assign word_par = 1'b0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if ((cnt_q == '0) && sin_valid) begin
         dir_d = rright;
      end
      if (sclr) begin
         cnt_d = '0;
      end else if (sin_valid) begin
         cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      data_d = data_q;
      dv_d   = dv_q;
      perr_d = perr_q;
      ovr_d  = 1'b0;
      if (word_done) begin
         if (!dv_q || dout_ack) begin
            data_d = word;
            dv_d   = 1'b1;
            perr_d = word_par;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (dout_ack) begin
         dv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         dir_q  <= DIR_LEFT;
         data_q <= '0;
         dv_q   <= 1'b0;
         ovr_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         data_q <= data_d;
         dv_q   <= dv_d;
         ovr_q  <= ovr_d;
         perr_q <= perr_d;
      end
   end

   assign dataout    = data_q;
   assign dout_valid = dv_q;
   assign overrun    = ovr_q;
   assign parity_err = perr_q;

endmodule
